xbr_arbiter: RTL
================

XBR_ARBITER -- requirements
Module: xbr_arbiter

Interface
REQ-001 SHALL have parameter ACCLEN, default 5: number of cycles xbrenab is held per access (legal range 2..15).
REQ-002 SHALL have port CLOCK  in  1  sole clock; all state changes on its rising edge.
REQ-003 SHALL have port RESET  in  1  synchronous, active-high reset.
REQ-004 SHALL have ports p0req, p1req, p2req  in  1 each  level request, held until the port's ack; p0 = PDP cpu memory cycle, p1 = ARM, p2 = DMA device.
REQ-005 SHALL have ports p0write, p1write, p2write  in  1 each  1 = write access, 0 = read access.
REQ-006 SHALL have ports p0addr, p1addr, p2addr  in  15 each  block RAM word address {field, 12-bit addr}.
REQ-007 SHALL have ports p0wdat, p1wdat, p2wdat  in  12 each  write data.
REQ-008 SHALL have ports p0ack, p1ack, p2ack  out  1 each  one-cycle completion pulse.
REQ-009 SHALL have ports p0rdat, p1rdat, p2rdat  out  12 each  read data for that port.
REQ-010 SHALL have ports xbraddr out 15, xbrwdat out 12, xbrrdat in 12, xbrenab out 1, xbrwena out 1: external block RAM bus.
REQ-011 SHALL have port busy  out  1  high while in ACCESS or DONE.
REQ-012 SHALL have port owner  out  2  port in ACCESS/DONE (0,1,2); 3 when IDLE.

Function
REQ-013 SHALL implement states IDLE, ACCESS, DONE with a 4-bit access counter.
REQ-014 IDLE: if any req high at an edge, SHALL grant one port, latch its write/addr/wdat, enter ACCESS; else stay IDLE.
REQ-015 Priority: p0 SHALL always win; between p1 and p2, round-robin -- whichever of p1/p2 was granted more recently loses a p1/p2 tie; after reset p1 wins the first tie.
REQ-016 A p0 grant SHALL NOT alter the p1/p2 round-robin pointer.
REQ-017 ACCESS: xbraddr/xbrwdat SHALL carry the latched values, xbrenab = 1, xbrwena = latched write, for exactly ACCLEN consecutive cycles.
REQ-018 On the last ACCESS edge, a read SHALL capture xbrrdat into the owner's rdat; writes SHALL leave all rdat unchanged.
REQ-019 DONE: xbrenab = xbrwena = 0, owner's ack = 1 for exactly one cycle, then IDLE unconditionally.
REQ-020 Latency: req sampled high in IDLE at edge E -> xbrenab high cycles E+1..E+ACCLEN -> ack high in cycle E+ACCLEN+1 -> next grant no earlier than edge E+ACCLEN+2.
REQ-021 Requester SHALL drop req in the cycle after ack; the arbiter's IDLE sample falls one edge later, so no duplicate grant occurs.
REQ-022 Request inputs SHALL be ignored outside IDLE; port inputs changing during ACCESS SHALL NOT affect the bus (latched copies used).
REQ-023 Requester dropping req mid-access: access SHALL complete and ack SHALL still pulse.
REQ-024 p0 worst-case wait from req to grant SHALL be ACCLEN+2 cycles (one in-flight access).
REQ-025 p1/p2 worst-case wait SHALL be bounded by one p1/p2 access plus p0 traffic; neither p1 nor p2 starves while the other holds req.
REQ-026 At most one ack SHALL be high in any cycle; xbrwena SHALL never be high while xbrenab is low.
REQ-027 rdat outputs SHALL hold their value until the next read completes for that port.

Reset
REQ-028 RESET at an edge SHALL force IDLE, counter 0, round-robin pointer to "p1 next", xbraddr = 0, xbrwdat = 0, xbrenab = 0, xbrwena = 0, all ack = 0, all rdat = 0, busy = 0, owner = 3.
REQ-029 RESET during ACCESS SHALL abort the access with no ack; the requester must reissue.

Verification
REQ-030 Write then read: p1 write addr 15'o12345 data 12'o7070, then p1 read same addr -> p1ack each time, p1rdat = 12'o7070 in the read's ack cycle.
REQ-031 Latency (ACCLEN = 5): p0 read req at edge 10 -> xbrenab high cycles 11-15, p0ack high cycle 16 only, busy low cycle 17.
REQ-032 Priority: p0, p1, p2 all raised at the same edge -> grant order p0, p1, p2; owner sequence 0, 1, 2.
REQ-033 Round-robin: p1 and p2 held continuously for 6 accesses -> grants alternate p1, p2, p1, p2, p1, p2; p0 inserted mid-stream preempts at the next IDLE without changing alternation.
REQ-034 Reset mid-op: RESET in the 3rd ACCESS cycle of a p2 write -> next cycle xbrenab = 0, xbrwena = 0, no p2ack; p2 reissue completes normally.
REQ-035 Stability: p1addr/p1wdat changed during ACCESS -> xbraddr/xbrwdat unchanged; a p1 write leaves p0rdat/p1rdat/p2rdat unchanged.

Source files
------------

// File: rtl/xbr_arbiter_if.sv
// Port bundle for xbr_arbiter: three requester ports, the block RAM bus and status.
interface xbr_arbiter_if;
    // Requester ports (p0 = PDP cpu, p1 = ARM, p2 = DMA device)
    logic        p0req,   p1req,   p2req;
    logic        p0write, p1write, p2write;
    logic [14:0] p0addr,  p1addr,  p2addr;
    logic [11:0] p0wdat,  p1wdat,  p2wdat;
    logic        p0ack,   p1ack,   p2ack;
    logic [11:0] p0rdat,  p1rdat,  p2rdat;

    // External block RAM bus
    logic [14:0] xbraddr;
    logic [11:0] xbrwdat;
    logic [11:0] xbrrdat;
    logic        xbrenab;
    logic        xbrwena;

    // Status
    logic        busy;
    logic [1:0]  owner;

    // Arbiter side
    modport slave (
        input  p0req, p1req, p2req,
        input  p0write, p1write, p2write,
        input  p0addr, p1addr, p2addr,
        input  p0wdat, p1wdat, p2wdat,
        output p0ack, p1ack, p2ack,
        output p0rdat, p1rdat, p2rdat,
        output xbraddr, xbrwdat, xbrenab, xbrwena,
        input  xbrrdat,
        output busy, owner
    );

    // Requesters plus the RAM itself
    modport master (
        output p0req, p1req, p2req,
        output p0write, p1write, p2write,
        output p0addr, p1addr, p2addr,
        output p0wdat, p1wdat, p2wdat,
        input  p0ack, p1ack, p2ack,
        input  p0rdat, p1rdat, p2rdat,
        input  xbraddr, xbrwdat, xbrenab, xbrwena,
        output xbrrdat,
        input  busy, owner
    );
endinterface

// File: rtl/xbr_arbiter.sv
// Three-port arbiter in front of a single block RAM. p0 has fixed priority,
// p1/p2 share the remaining bandwidth round-robin. Each access holds the RAM
// enable for ACCLEN cycles, then pulses the owner's ack for one cycle.
module xbr_arbiter #(
    parameter int ACCLEN = 5
) (
    input  logic          CLOCK,
    input  logic          RESET,
    xbr_arbiter_if.slave  io_bus
);
    localparam logic [3:0] LP_LAST = 4'(ACCLEN - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [3:0]  r_cnt;
    logic        r_p2_first;    // 1: p2 wins the next p1/p2 tie
    logic [1:0]  r_owner;
    logic        r_write;
    logic [14:0] r_addr;
    logic [11:0] r_wdat;
    logic [11:0] r_rdat [3];
    logic        w_grant;
    logic [1:0]  w_grant_id;
    logic        w_last;

    assign w_last = (r_cnt == LP_LAST);

    // Select the winner: p0 always, otherwise round-robin between p1 and p2.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        w_grant    = io_bus.p0req | io_bus.p1req | io_bus.p2req;
        w_grant_id = 2'd0;
        if (io_bus.p0req) begin
            w_grant_id = 2'd0;
        end else if (io_bus.p1req && !(io_bus.p2req && r_p2_first)) begin
            w_grant_id = 2'd1;
        end else if (io_bus.p2req) begin
            w_grant_id = 2'd2;
        end
    end

    // State register.
    always_ff @(posedge CLOCK) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (RESET) r_state <= ST_IDLE;
        else       r_state <= w_state_next;
    end

    // Next state plus RAM strobes, acks and status decoded from the current state.
    always_comb begin
        w_state_next   = r_state;
        io_bus.xbrenab = 1'b0;
        io_bus.xbrwena = 1'b0;
        io_bus.busy    = 1'b0;
        io_bus.owner   = 2'd3;
        io_bus.p0ack   = 1'b0;
        io_bus.p1ack   = 1'b0;
        io_bus.p2ack   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_grant) w_state_next = ST_ACCESS;
            end
            ST_ACCESS: begin
                io_bus.xbrenab = 1'b1;
                io_bus.xbrwena = r_write;
                io_bus.busy    = 1'b1;
                io_bus.owner   = r_owner;
                if (w_last) w_state_next = ST_DONE;
            end
            ST_DONE: begin
                io_bus.busy    = 1'b1;
                io_bus.owner   = r_owner;
                io_bus.p0ack   = (r_owner == 2'd0);
                io_bus.p1ack   = (r_owner == 2'd1);
                io_bus.p2ack   = (r_owner == 2'd2);
                w_state_next   = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Latch the granted request, count access cycles, move the round-robin
    // pointer and capture read data on the last access edge.
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            r_cnt      <= 4'd0;
            r_p2_first <= 1'b0;
            r_owner    <= 2'd0;
            r_write    <= 1'b0;
            r_addr     <= 15'd0;
            r_wdat     <= 12'd0;
            // NOTE: read-data registers are visible outputs, so this small array is reset like any other register.
            for (int i = 0; i < 3; i++) r_rdat[i] <= 12'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_grant) begin
                        r_cnt   <= 4'd0;
                        r_owner <= w_grant_id;
                        case (w_grant_id)
                            2'd0: begin
                                r_write <= io_bus.p0write;
                                r_addr  <= io_bus.p0addr;
                                r_wdat  <= io_bus.p0wdat;
                            end
                            2'd1: begin
                                r_write    <= io_bus.p1write;
                                r_addr     <= io_bus.p1addr;
                                r_wdat     <= io_bus.p1wdat;
                                r_p2_first <= 1'b1;
                            end
                            default: begin
                                r_write    <= io_bus.p2write;
                                r_addr     <= io_bus.p2addr;
                                r_wdat     <= io_bus.p2wdat;
                                r_p2_first <= 1'b0;
                            end
                        endcase
                    end
                end
                ST_ACCESS: begin
                    if (!w_last) begin
                        r_cnt <= r_cnt + 4'd1;
                    end else if (!r_write) begin
                        case (r_owner)
                            2'd0:    r_rdat[0] <= io_bus.xbrrdat;
                            2'd1:    r_rdat[1] <= io_bus.xbrrdat;
                            default: r_rdat[2] <= io_bus.xbrrdat;
                        endcase
                    end
                end
                default: ;
            endcase
        end
    end

    assign io_bus.xbraddr = r_addr;
    assign io_bus.xbrwdat = r_wdat;
    assign io_bus.p0rdat  = r_rdat[0];
    assign io_bus.p1rdat  = r_rdat[1];
    assign io_bus.p2rdat  = r_rdat[2];
endmodule
